// File: rtl/lcd1602_pkg.sv
// Shared types, default HD44780 timing (in clock cycles) and command codes
// for the LCD1602 parallel-bus driver.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int unsigned DEF_CLK_HZ      = 27_000_000;
  localparam int unsigned DEF_T_SETUP     = 2;
  localparam int unsigned DEF_T_EN_HIGH   = 16;
  localparam int unsigned DEF_T_HOLD      = 2;
  localparam int unsigned DEF_T_EXEC      = 1350;
  localparam int unsigned DEF_T_EXEC_LONG = 55_000;
  localparam int unsigned DEF_T_POWERUP   = 1_080_000;

  localparam logic [7:0] CMD_CLEAR           = 8'h01;
  localparam logic [7:0] CMD_HOME            = 8'h02;
  localparam logic [7:0] CMD_FUNC_8BIT_2LINE = 8'h38;
  localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;
  localparam logic [7:0] CMD_SHIFT_LEFT      = 8'h18;
  localparam logic [7:0] CMD_DDRAM_LINE1     = 8'h80;
  localparam logic [7:0] CMD_DDRAM_LINE2     = 8'hC0;

  function automatic int unsigned max6(input int unsigned a, b, c, d, e, f);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

endpackage

// File: rtl/lcd1602_bus_driver.sv
// HD44780 write-only bus driver: one byte per handshake, EN strobe timing and
// execute wait driven by a single shared down-counter.
module lcd1602_bus_driver
  import lcd1602_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned T_SETUP     = DEF_T_SETUP,
  parameter int unsigned T_EN_HIGH   = DEF_T_EN_HIGH,
  parameter int unsigned T_HOLD      = DEF_T_HOLD,
  parameter int unsigned T_EXEC      = DEF_T_EXEC,
  parameter int unsigned T_EXEC_LONG = DEF_T_EXEC_LONG,
  parameter int unsigned T_POWERUP   = DEF_T_POWERUP
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int unsigned T_MAX = max6(T_SETUP, T_EN_HIGH, T_HOLD, T_EXEC, T_EXEC_LONG, T_POWERUP);
  localparam int          CW    = $clog2(T_MAX + 1);

  if (CLK_HZ == 0 || T_SETUP == 0 || T_EN_HIGH == 0 || T_HOLD == 0 ||
      T_EXEC == 0 || T_EXEC_LONG == 0 || T_POWERUP == 0) begin : g_bad_param
    $error("lcd1602_bus_driver: every timing parameter must be >= 1");
  end

  lcd_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept;
  logic          exec_long;

  // Clear and home (rs=0, data[7:2]==0) need the long execute time.
  assign exec_long = !LCD_RS && (LCD_DATA[7:2] == 6'd0);
  assign LCD_RW    = 1'b0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      ST_POWERUP: begin
        if (cnt == CW'(1)) state_n = ST_IDLE;
        else               cnt_n   = cnt - CW'(1);
      end
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_n = ST_SETUP;
          cnt_n   = CW'(T_SETUP);
        end
      end
      ST_SETUP: begin
        if (cnt == CW'(1)) begin
          state_n = ST_PULSE;
          cnt_n   = CW'(T_EN_HIGH);
        end else cnt_n = cnt - CW'(1);
      end
      ST_PULSE: begin
        if (cnt == CW'(1)) begin
          state_n = ST_HOLD;
          cnt_n   = CW'(T_HOLD);
        end else cnt_n = cnt - CW'(1);
      end
      ST_HOLD: begin
        if (cnt == CW'(1)) begin
          state_n = ST_EXEC;
          cnt_n   = exec_long ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
        end else cnt_n = cnt - CW'(1);
      end
      ST_EXEC: begin
        if (cnt == CW'(1)) state_n = ST_IDLE;
        else               cnt_n   = cnt - CW'(1);
      end
      default: begin
        state_n = ST_POWERUP;
        cnt_n   = CW'(T_POWERUP);
      end
    endcase
  end

  // Status and strobe are registered from the next state so they line up
  // with the state register rather than trailing it by a cycle.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state    <= ST_POWERUP;
      cnt      <= CW'(T_POWERUP);
      in_ready <= 1'b0;
      busy     <= 1'b1;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      in_ready <= (state_n == ST_IDLE);
      busy     <= (state_n != ST_IDLE);
      LCD_EN   <= (state_n == ST_PULSE);
      if (accept) begin
        LCD_RS   <= in_rs;
        LCD_DATA <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_driver.sv
// Randomized bench for lcd1602_bus_driver: timeline model of each transfer
// checked every cycle, plus literal latency/strobe expectations.
module tb_lcd1602_bus_driver;
  localparam int TS = 2, TE = 4, TH = 2, TX = 10, TXL = 40, TP = 20;

  logic       iclk = 1'b0, irst = 1'b0;
  logic       in_valid = 1'b0, in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, busy, LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] LCD_DATA;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  lcd1602_bus_driver #(
    .T_SETUP(TS), .T_EN_HIGH(TE), .T_HOLD(TH),
    .T_EXEC(TX), .T_EXEC_LONG(TXL), .T_POWERUP(TP)
  ) dut (
    .iclk(iclk), .irst(irst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: m_n counts edges since reset release; a transfer accepted
  // at edge a strobes EN over [a+TS, a+TS+TE) and frees the bus at a+latency.
  int         m_n = 0, m_ready_t = TP, m_acc = -1000;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      m_n <= 0; m_ready_t <= TP; m_acc <= -1000; m_rs <= 1'b0; m_data <= 8'h00;
    end else begin
      if (m_n >= m_ready_t && in_valid) begin
        m_acc     <= m_n + 1;
        m_rs      <= in_rs;
        m_data    <= in_data;
        m_ready_t <= m_n + 1 + TS + TE + TH + ((!in_rs && in_data < 8'd4) ? TXL : TX);
      end
      m_n <= m_n + 1;
    end
  end

  always @(negedge iclk) begin
    if (chk_en) begin
      chk("model_in_ready", 32'(in_ready), 32'(m_n >= m_ready_t));
      chk("model_busy",     32'(busy),     32'(m_n < m_ready_t));
      chk("model_en",       32'(LCD_EN),   32'(m_n >= m_acc + TS && m_n < m_acc + TS + TE));
      chk("model_rs",       32'(LCD_RS),   32'(m_rs));
      chk("model_data",     32'(LCD_DATA), 32'(m_data));
      chk("model_rw",       32'(LCD_RW),   32'(0));
    end
  end

  task automatic tick();
    @(posedge iclk); #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 500; i++) begin
      if (in_ready) return;
      tick();
    end
    chk("wait_ready_timeout", 32'(in_ready), 32'(1));
  endtask

  // One handshake; returns edges until in_ready, first EN-high edge, EN-high count.
  task automatic send(input logic rs, input logic [7:0] d, input bit noise,
                      output int lat, output int rise, output int en_n);
    wait_ready();
    in_rs = rs; in_data = d; in_valid = 1'b1;
    tick();
    chk("accept_rs", 32'(LCD_RS), 32'(rs));
    chk("accept_data", 32'(LCD_DATA), 32'(d));
    in_valid = 1'b0;
    lat = 0; rise = -1; en_n = 0;
    for (int i = 1; i <= 500; i++) begin
      if (noise) begin
        in_valid = 1'($urandom); in_rs = 1'($urandom); in_data = 8'($urandom);
      end
      tick();
      if (LCD_EN) begin
        if (en_n == 0) rise = i;
        en_n++;
      end
      if (in_ready) begin
        lat = i; in_valid = 1'b0;
        break;
      end
    end
    if (lat == 0) chk("send_timeout", 32'(in_ready), 32'(1));
    chk("held_data", 32'(LCD_DATA), 32'(d));
    chk("held_rs", 32'(LCD_RS), 32'(rs));
  endtask

  task automatic powerup_count(input string nm);
    int k, en_seen;
    k = 0; en_seen = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (LCD_EN) en_seen++;
      if (in_ready) begin k = i; break; end
    end
    chk({nm, "_latency"}, 32'(k), 32'(TP));
    chk({nm, "_no_en"}, 32'(en_seen), 32'(0));
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rise, en_n;
    logic [7:0] cmds [3];
    int         cmd_lat [3];
    logic       rs;
    logic [7:0] d;
    int nacc, rises, last_rise, acc_cyc;
    logic prev_en, prev_ready;

    cmds = '{8'h01, 8'h02, 8'h38};
    cmd_lat = '{48, 48, 18};

    #1 irst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_en", 32'(LCD_EN), 32'(0));
    chk("rst_rs", 32'(LCD_RS), 32'(0));
    chk("rst_data", 32'(LCD_DATA), 32'(0));
    chk("rst_rw", 32'(LCD_RW), 32'(0));
    chk_en = 1'b1;
    tick(); tick();
    irst = 1'b0;
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h41;
    powerup_count("powerup");
    // in_valid held: taken on the first IDLE edge
    tick();
    chk("held_valid_accept", 32'(LCD_DATA), 32'h41);
    chk("held_valid_busy", 32'(busy), 32'(1));
    in_valid = 1'b0;

    send(1'b1, 8'h43, 1'b0, lat, rise, en_n);
    chk("char43_latency", 32'(lat), 32'(18));
    chk("char43_en_rise", 32'(rise), 32'(2));
    chk("char43_en_width", 32'(en_n), 32'(4));

    for (int i = 0; i < 3; i++) begin
      send(1'b0, cmds[i], 1'b1, lat, rise, en_n);
      chk("cmd_latency", 32'(lat), 32'(cmd_lat[i]));
      chk("cmd_en_width", 32'(en_n), 32'(TE));
    end

    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom);
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      send(rs, d, 1'b1, lat, rise, en_n);
      chk("rand_latency", 32'(lat), 32'(TS + TE + TH + ((!rs && d < 8'd4) ? TXL : TX)));
      chk("rand_en_rise", 32'(rise), 32'(TS));
      chk("rand_en_width", 32'(en_n), 32'(TE));
    end

    // Reset in the middle of the EN pulse
    wait_ready();
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !LCD_EN; i++) tick();
    chk("pre_abort_en", 32'(LCD_EN), 32'(1));
    #2 irst = 1'b1;
    #1;
    chk("abort_en", 32'(LCD_EN), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(0));
    chk("abort_busy", 32'(busy), 32'(1));
    chk("abort_rs", 32'(LCD_RS), 32'(0));
    chk("abort_data", 32'(LCD_DATA), 32'(0));
    tick(); tick();
    irst = 1'b0;
    powerup_count("repowerup");

    // 16 characters with in_valid held; each lands on the first IDLE cycle
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h30;
    nacc = 0; rises = 0; last_rise = -1; acc_cyc = 0;
    prev_en = LCD_EN; prev_ready = in_ready;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      tick();
      if (prev_ready && in_valid) begin
        nacc++; acc_cyc = cyc;
        if (nacc == 16) in_valid = 1'b0;
        else in_data = 8'h30 + 8'(nacc);
      end
      if (in_ready && !prev_ready) chk("b2b_latency", 32'(cyc - acc_cyc), 32'(18));
      if (LCD_EN && !prev_en) begin
        rises++;
        if (last_rise >= 0) chk("b2b_en_spacing", 32'(cyc - last_rise), 32'(19));
        last_rise = cyc;
      end
      prev_en = LCD_EN; prev_ready = in_ready;
      if (nacc == 16 && in_ready) break;
    end
    chk("b2b_accepts", 32'(nacc), 32'(16));
    chk("b2b_en_pulses", 32'(rises), 32'(16));
    chk("b2b_last_data", 32'(LCD_DATA), 32'h3F);

    tick(); tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
